mux7_rr_arbiter: RTL and testbench
==================================

Name: mux7_rr_arbiter

Overview:
- Round-robin arbiter that shares one 7:1 single-bit mux channel among 7 requesters.
- Each requester raises a request and presents one data bit.
- The block grants one requester at a time and drives the mux select code (3'b000–3'b110 = input 0–6; 3'b111 = idle, output forced 0).
- The granted input's bit is forwarded with a valid flag; grant length is bounded by a hold limit for fairness.

Parameters:
HOLD_MAX, 8, maximum consecutive cycles per grant; legal range 1..255.

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
enable  input  1  arbitration enable; low forces release and idle
req  input  7  request per requester, level-sensitive
data  input  7  data bit per requester; data[i] pairs with req[i]
sel  output  3  registered mux select; 3'b111 when idle
grant  output  7  registered one-hot grant; all zero when idle
out_bit  output  1  data[sel] while granted, else 0 (combinational from registered sel)
out_valid  output  1  high while in GRANT
busy  output  1  identical to out_valid; kept for status LED

Behaviour:
- Registered state:
  - state ∈ {IDLE, GRANT}
  - sel[2:0]
  - grant[6:0]
  - ptr[2:0], range 0..6 (next search start)
  - hold[7:0]
- Reset, asynchronous and immediate on Resetn=0 even mid-grant:
  - state=IDLE, sel=3'b111, grant=0, ptr=0, hold=0.
  - Consequently out_bit=0, out_valid=0, busy=0.
- Search function:
  - Scan indices ptr, ptr+1, …, 6, 0, …, ptr-1; pick the first i with req[i]=1.
  - Wrap is 6→0; ptr never holds 7.
- IDLE:
  - Outputs are idle values.
  - On an edge with enable=1 and req≠0: state←GRANT, sel←winner, grant←one-hot(winner), hold←0.
  - Latency: request sampled at edge t, grant visible after edge t (one cycle).
- GRANT:
  - out_valid=1; out_bit=data[sel], which follows data combinationally within the cycle.
  - The hold counter increments each edge while no release occurs.
- Release conditions, evaluated at each edge while in GRANT (any one suffices):
  - (a) req[sel]=0
  - (b) hold==HOLD_MAX-1, i.e. the grant has lasted HOLD_MAX cycles
  - (c) enable=0
- On release:
  - ptr←(sel==6)?0:sel+1.
  - If enable=1 and the search from the new ptr finds a winner (current requester included, searched last): stay in GRANT, load new sel/grant, hold←0. There is no idle gap, so back-to-back grants occur.
  - Otherwise state←IDLE, sel←3'b111, grant←0.
- Sole requester hitting the hold limit:
  - Re-granted to itself with hold reset; sel unchanged, grant stays high.
- Simultaneous events:
  - Condition (c) dominates: always IDLE, but ptr still advances.
  - A new request arriving on the same edge as a release participates in the search.
  - Requests from non-granted inputs never preempt a grant.
- HOLD_MAX=1: every grant lasts exactly one cycle; pure rotation.
- Timing: no combinational path from req to sel/grant; out_bit is the only combinational output.

Test Plan:
1. Resetn=0 with req=7'h7F, enable=1 → sel=3'b111, grant=0, out_valid=0, out_bit=0. Release reset → first grant is req[0] one edge later (ptr=0).
2. HOLD_MAX=4, only req[3]=1, data[3] toggling each cycle:
   - grant=7'b0001000 one cycle after request.
   - out_bit tracks data[3].
   - After 4 cycles, re-grant to 3 with hold reset; grant continuous, no gap.
3. HOLD_MAX=2, req=7'b1000101 held constant → grant sequence 0,0,2,2,6,6,0,0 with sel 0,0,2,2,6,6,0,0; out_valid never drops.
4. Wrap: after a grant to 5 releases, req=7'b0010001 → ptr=6, search 6→0, next grant=0 (not 4).
5. HOLD_MAX=8, req[2] granted, then drops after 1 granted cycle:
   - Release at the next edge; state IDLE, sel=3'b111, ptr=3.
   - A subsequent req=7'b0000101 grants 0.
6. Mid-grant hazards:
   - enable=0 during a grant to 4 → IDLE at next edge, ptr=5, no re-grant.
   - Separately, Resetn pulsed low mid-grant → outputs clear immediately without waiting for a Clock edge; ptr=0.

Source files
------------

// File: rtl/mux7_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux7_rr_arbiter
//
// Round-robin arbiter that shares one 7:1 single-bit mux channel among seven
// requesters. One requester is granted at a time. The registered select code
// steers the mux: 3'b000..3'b110 pick input 0..6, and 3'b111 means idle with
// the output forced to 0. No requester can hold the channel for more than
// HOLD_MAX consecutive cycles.
//
// Parameters
//   HOLD_MAX   maximum consecutive cycles per grant (legal range 1..255)
//
// Ports
//   Clock      input   1  system clock, rising edge
//   Resetn     input   1  asynchronous active-low reset
//   enable     input   1  arbitration enable; low forces release and idle
//   req        input   7  level-sensitive request per requester
//   data       input   7  data bit per requester, data[i] pairs with req[i]
//   sel        output  3  registered mux select, 3'b111 when idle
//   grant      output  7  registered one-hot grant, zero when idle
//   out_bit    output  1  data[sel] while granted, else 0 (combinational)
//   out_valid  output  1  high while a grant is active
//   busy       output  1  same as out_valid (status LED)
//   state_dbg  output  1  current FSM state (0 = IDLE, 1 = GRANT)
//   ptr_dbg    output  3  round-robin search start pointer (0..6)
//
// Handshake: req[i] is a level. A grant is a registered response that
// appears one edge after the request is sampled. The requester keeps req[i]
// high for as long as it wants the channel, and dropping it releases the
// channel at the next edge. out_valid qualifies out_bit in every cycle.
// ---------------------------------------------------------------------------
module mux7_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       enable,
    input  logic [6:0] req,
    input  logic [6:0] data,
    output logic [2:0] sel,
    output logic [6:0] grant,
    output logic       out_bit,
    output logic       out_valid,
    output logic       busy,
    output logic       state_dbg,
    output logic [2:0] ptr_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [2:0] SEL_IDLE  = 3'b111;
    // Value of the hold counter during the last cycle a grant may last.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [2:0] sel_q,   sel_d;
    logic [6:0] grant_q, grant_d;
    logic [2:0] ptr_q,   ptr_d;
    logic [7:0] hold_q,  hold_d;

    logic [7:0] req_ext;
    logic [7:0] data_ext;
    logic [2:0] ptr_rel;
    logic [3:0] win_idle;
    logic [3:0] win_rel;
    logic       release_now;

    // Round-robin search. Returns {found, index}. The candidate at offset 0
    // from start has the highest priority, and the scan wraps 6 -> 0. The
    // loop runs from the far end back so that the nearest hit is written last.
    function automatic logic [3:0] search(input logic [6:0] r, input logic [2:0] start);
        logic [7:0] r_ext;
        logic [3:0] idx;
        logic [3:0] res;
        r_ext = {1'b0, r};
        res   = 4'b0000;
        for (int k = 6; k >= 0; k--) begin
            idx = {1'b0, start} + 4'(k);
            if (idx >= 4'd7) begin
                idx = idx - 4'd7;
            end
            if (r_ext[idx[2:0]]) begin
                res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

    // The top bit is padding, so indexing with sel==3'b111 reads a constant 0.
    assign req_ext  = {1'b0, req};
    assign data_ext = {1'b0, data};

    // Pointer after releasing the current holder. The holder itself becomes
    // the last candidate of the next search.
    assign ptr_rel  = (sel_q == 3'd6) ? 3'd0 : sel_q + 3'd1;

    assign win_idle = search(req, ptr_q);
    assign win_rel  = search(req, ptr_rel);

    assign release_now = !req_ext[sel_q] || (hold_q == HOLD_LAST) || !enable;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            sel_q   <= SEL_IDLE;
            grant_q <= 7'b0;
            ptr_q   <= 3'd0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;

        case (state_q)
            IDLE: begin
                if (enable && win_idle[3]) begin
                    state_d = GRANT;
                    sel_d   = win_idle[2:0];
                    grant_d = 7'(1) << win_idle[2:0];
                    hold_d  = 8'd0;
                end
            end

            GRANT: begin
                if (release_now) begin
                    // The pointer advances on every release, including one
                    // forced by enable going low.
                    ptr_d = ptr_rel;
                    if (enable && win_rel[3]) begin
                        // Back-to-back handover with no idle gap. A sole
                        // requester at its hold limit lands here and is
                        // re-granted to itself with a fresh hold count.
                        state_d = GRANT;
                        sel_d   = win_rel[2:0];
                        grant_d = 7'(1) << win_rel[2:0];
                        hold_d  = 8'd0;
                    end else begin
                        state_d = IDLE;
                        sel_d   = SEL_IDLE;
                        grant_d = 7'b0;
                        hold_d  = 8'd0;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
                sel_d   = SEL_IDLE;
                grant_d = 7'b0;
                hold_d  = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sel       = sel_q;
    assign grant     = grant_q;
    assign out_valid = (state_q == GRANT);
    assign busy      = out_valid;
    // The only combinational path: data to out_bit through the registered select.
    assign out_bit   = out_valid & data_ext[sel_q];
    assign state_dbg = state_q;
    assign ptr_dbg   = ptr_q;

endmodule

// File: tb/tb_mux7_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux7_rr_arbiter
//
// Four arbiters with HOLD_MAX = 1, 2, 4 and 8 share one set of inputs. Each
// arbiter is compared against a grant-level reference model that tracks
// (granted, holder, pointer, cycles held). Hand-derived expectations cover
// the directed scenarios. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_mux7_rr_arbiter;

    localparam int NI = 4;
    localparam int HOLDS[NI] = '{1, 2, 4, 8};

    // ---------------- clock / reset ----------------
    logic       Clock;
    logic       Resetn;
    logic       enable;
    logic [6:0] req;
    logic [6:0] data;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    logic [2:0] sel_o   [NI];
    logic [6:0] grant_o [NI];
    logic       bit_o   [NI];
    logic       valid_o [NI];
    logic       busy_o  [NI];
    logic       st_o    [NI];
    logic [2:0] ptr_o   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mux7_rr_arbiter #(.HOLD_MAX(HOLDS[g])) u_dut (
            .Clock     (Clock),
            .Resetn    (Resetn),
            .enable    (enable),
            .req       (req),
            .data      (data),
            .sel       (sel_o[g]),
            .grant     (grant_o[g]),
            .out_bit   (bit_o[g]),
            .out_valid (valid_o[g]),
            .busy      (busy_o[g]),
            .state_dbg (st_o[g]),
            .ptr_dbg   (ptr_o[g])
        );
    end

    // ---------------- reference model ----------------
    int m_gr  [NI];   // 1 while a requester holds the channel
    int m_cur [NI];   // current holder
    int m_ptr [NI];   // next search start
    int m_len [NI];   // cycles the current grant has lasted

    int tests_run;
    int tests_failed;

    logic [16:0] exp_q[$];

    function automatic int find_from(input logic [6:0] r, input int start);
        for (int k = 0; k < 7; k++) begin
            int idx;
            idx = (start + k) % 7;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_gr[i]  = 0;
            m_cur[i] = 0;
            m_ptr[i] = 0;
            m_len[i] = 0;
        end
    endtask

    task automatic model_step(input logic en, input logic [6:0] r);
        int w;
        for (int i = 0; i < NI; i++) begin
            if (m_gr[i] == 0) begin
                if (en && r != 7'd0) begin
                    m_cur[i] = find_from(r, m_ptr[i]);
                    m_gr[i]  = 1;
                    m_len[i] = 1;
                end
            end else if (!r[m_cur[i]] || m_len[i] == HOLDS[i] || !en) begin
                m_ptr[i] = (m_cur[i] + 1) % 7;
                w = find_from(r, m_ptr[i]);
                if (en && w >= 0) begin
                    m_cur[i] = w;
                    m_len[i] = 1;
                end else begin
                    m_gr[i] = 0;
                end
            end else begin
                m_len[i] = m_len[i] + 1;
            end
        end
    endtask

    // Packing: {state, busy, valid, out_bit, sel[2:0], grant[6:0], ptr[2:0]}
    function automatic logic [16:0] model_expect(input int i);
        logic [2:0] s;
        logic [6:0] g;
        logic       v;
        logic       b;
        v = (m_gr[i] != 0);
        s = v ? 3'(m_cur[i]) : 3'b111;
        g = v ? (7'(1) << m_cur[i]) : 7'd0;
        b = v ? data[m_cur[i]] : 1'b0;
        return {v, v, v, b, s, g, 3'(m_ptr[i])};
    endfunction

    function automatic logic [16:0] dut_pack(input int i);
        return {st_o[i], busy_o[i], valid_o[i], bit_o[i], sel_o[i], grant_o[i], ptr_o[i]};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [16:0] e;
        for (int i = 0; i < NI; i++) exp_q.push_back(model_expect(i));
        for (int i = 0; i < NI; i++) begin
            e = exp_q.pop_front();
            check_val($sformatf("%s_h%0d", tag, HOLDS[i]), 32'(dut_pack(i)), 32'(e));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge. Drives the inputs, lets one rising edge
    // happen, and returns at the next falling edge after the model step.
    task automatic apply(input logic en, input logic [6:0] r, input logic [6:0] d);
        enable = en;
        req    = r;
        data   = d;
        @(posedge Clock);
        model_step(en, r);
        @(negedge Clock);
    endtask

    // Asserts reset between clock edges, checks that the outputs clear
    // without an edge, then releases reset at the next falling edge.
    task automatic do_reset(input string tag);
        #2 Resetn = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("%s_sel_h%0d", tag, HOLDS[i]), 32'(sel_o[i]), 32'h7);
            check_val($sformatf("%s_ptr_h%0d", tag, HOLDS[i]), 32'(ptr_o[i]), 32'h0);
        end
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [6:0] req;
        logic [2:0] exp_sel;
        logic [6:0] exp_grant;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_reset();

        // HOLD_MAX=2 arbiter with requests 0, 2, 6 held constant
        tbl[0] = '{7'b1000101, 3'd0, 7'b0000001};
        tbl[1] = '{7'b1000101, 3'd0, 7'b0000001};
        tbl[2] = '{7'b1000101, 3'd2, 7'b0000100};
        tbl[3] = '{7'b1000101, 3'd2, 7'b0000100};
        tbl[4] = '{7'b1000101, 3'd6, 7'b1000000};
        tbl[5] = '{7'b1000101, 3'd6, 7'b1000000};
        tbl[6] = '{7'b1000101, 3'd0, 7'b0000001};
        tbl[7] = '{7'b1000101, 3'd0, 7'b0000001};

        // --- 1: reset with every request pending ---
        Resetn = 1'b0;
        enable = 1'b1;
        req    = 7'h7F;
        data   = 7'h7F;
        @(negedge Clock);
        check_all("rst");
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("rst_sel_h%0d", HOLDS[i]), 32'(sel_o[i]), 32'h7);
            check_val($sformatf("rst_grant_h%0d", HOLDS[i]), 32'(grant_o[i]), 32'h0);
            check_val($sformatf("rst_valid_h%0d", HOLDS[i]), 32'(valid_o[i]), 32'h0);
            check_val($sformatf("rst_bit_h%0d", HOLDS[i]), 32'(bit_o[i]), 32'h0);
        end
        Resetn = 1'b1;
        apply(1'b1, 7'h7F, 7'h7F);
        check_all("first");
        for (int i = 0; i < NI; i++)
            check_val($sformatf("first_sel_h%0d", HOLDS[i]), 32'(sel_o[i]), 32'h0);

        // --- 3: HOLD_MAX=2 rotation table ---
        do_reset("rst3");
        for (int v = 0; v < 8; v++) begin
            apply(1'b1, tbl[v].req, 7'($urandom));
            check_all($sformatf("rot%0d", v));
            check_val($sformatf("rot%0d_sel", v), 32'(sel_o[1]), 32'(tbl[v].exp_sel));
            check_val($sformatf("rot%0d_grant", v), 32'(grant_o[1]), 32'(tbl[v].exp_grant));
            check_val($sformatf("rot%0d_valid", v), 32'(valid_o[1]), 32'h1);
        end

        // --- 2: HOLD_MAX=4, sole requester 3, data[3] toggling ---
        do_reset("rst2");
        for (int c = 0; c < 10; c++) begin
            apply(1'b1, 7'b0001000, (c % 2 == 1) ? 7'b0001000 : 7'b0000000);
            check_all($sformatf("solo%0d", c));
            check_val($sformatf("solo%0d_grant", c), 32'(grant_o[2]), 32'h08);
            check_val($sformatf("solo%0d_bit", c), 32'(bit_o[2]), 32'(c % 2));
            if (c == 4)
                check_val("solo_regrant_ptr", 32'(ptr_o[2]), 32'h4);
            // data flip between edges must show on out_bit without an edge
            data = data ^ 7'b0001000;
            #1;
            check_all($sformatf("solo%0d_comb", c));
            check_val($sformatf("solo%0d_bitflip", c), 32'(bit_o[2]), 32'((c + 1) % 2));
        end

        // --- 4: wrap 6 -> 0 after a grant to 5 ---
        @(negedge Clock);
        do_reset("rst4");
        apply(1'b1, 7'b0100000, 7'h7F);
        check_all("wrap_a");
        check_val("wrap_a_sel", 32'(sel_o[3]), 32'h5);
        apply(1'b1, 7'b0010001, 7'h7F);
        check_all("wrap_b");
        check_val("wrap_b_sel", 32'(sel_o[3]), 32'h0);
        check_val("wrap_b_ptr", 32'(ptr_o[3]), 32'h6);

        // --- 5: early drop of req[2] under HOLD_MAX=8 ---
        do_reset("rst5");
        apply(1'b1, 7'b0000100, 7'h00);
        check_val("drop_sel", 32'(sel_o[3]), 32'h2);
        apply(1'b1, 7'b0000000, 7'h00);
        check_all("drop_idle");
        check_val("drop_idle_sel", 32'(sel_o[3]), 32'h7);
        check_val("drop_idle_ptr", 32'(ptr_o[3]), 32'h3);
        apply(1'b1, 7'b0000101, 7'h00);
        check_all("drop_next");
        check_val("drop_next_sel", 32'(sel_o[3]), 32'h0);

        // --- 6a: enable low mid-grant ---
        do_reset("rst6");
        apply(1'b1, 7'b0010000, 7'h10);
        check_val("en_sel", 32'(sel_o[3]), 32'h4);
        apply(1'b0, 7'b0010000, 7'h10);
        check_all("en_off");
        check_val("en_off_sel", 32'(sel_o[3]), 32'h7);
        check_val("en_off_ptr", 32'(ptr_o[3]), 32'h5);
        apply(1'b0, 7'b0010000, 7'h10);
        check_val("en_off_stay", 32'(valid_o[3]), 32'h0);

        // --- 6b: asynchronous reset mid-grant ---
        apply(1'b1, 7'b0010000, 7'h10);
        check_val("mid_sel", 32'(sel_o[3]), 32'h4);
        do_reset("mid_rst");

        // --- randomized phase ---
        for (int n = 0; n < 3000; n++) begin
            logic [6:0] r;
            logic       en;
            case ($urandom_range(0, 3))
                0: r = 7'($urandom);
                1: r = 7'(1) << $urandom_range(0, 6);
                2: r = 7'($urandom) & 7'($urandom);
                default: r = (n % 17 == 0) ? 7'd0 : 7'($urandom) | 7'($urandom);
            endcase
            en = ($urandom_range(0, 9) != 0);
            apply(en, r, 7'($urandom));
            check_all($sformatf("rnd%0d", n));
            if ($urandom_range(0, 7) == 0) begin
                data = 7'($urandom);
                #1;
                check_all($sformatf("rnd%0d_d", n));
            end
            if ($urandom_range(0, 199) == 0)
                do_reset($sformatf("rnd%0d_rst", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
